flit_rx_buffer: RTL and testbench

- Receive-side stage directly downstream of checksum calculation on each router input link.
- Consumes the flit and its checksum-valid flag. Good flits go into a small FIFO feeding the router core; bad flits are dropped.
- Issues one-cycle ACK/NACK pulses back to the link sender, backs off after a NACK, and latches a link fault after repeated consecutive errors.

---
 rtl/flit_rx_buffer.sv | 122 ++++++++++++
 tb/tb_flit_rx_buffer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_rx_buffer.sv
// Receive-side flit buffer: drops bad-checksum flits with NACK/backoff,
// queues good flits in a small FIFO and latches a link fault on repeated errors.
package types;
  typedef struct packed {
    logic [7:0] payload;
    logic [7:0] checksum;
  } flit_t;
endpackage

module flit_rx_buffer #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned BACKOFF_CYCLES = 4,
  parameter int unsigned ERR_CNT_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  types::flit_t             in_flit,
  input  logic                     in_checksum_ok,
  output logic                     out_valid,
  input  logic                     out_ready,
  output types::flit_t             out_flit,
  output logic                     ack,
  output logic                     nack,
  output logic                     fault,
  input  logic                     clear_fault,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(MAX_RETRY + 1);
  localparam int unsigned BW = $clog2(BACKOFF_CYCLES + 1);
  localparam logic [PW:0]   FULL      = (PW + 1)'(DEPTH);
  localparam logic [CW-1:0] RETRY_LIM = CW'(MAX_RETRY);
  localparam logic [BW-1:0] BO_LOAD   = BW'(BACKOFF_CYCLES);

  typedef enum logic [1:0] {RUN, BACKOFF, FAULT} state_t;

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] consec;
  logic [CW-1:0] consec_inc;
  logic [BW-1:0] bo_cnt;
  types::flit_t  mem [DEPTH];

  logic accept;
  logic push;
  logic bad;
  logic pop;

  // Readiness depends only on registered state, never on in_valid.
  assign in_ready   = (state == RUN) && (occupancy < FULL);
  assign accept     = in_valid && in_ready;
  assign push       = accept && in_checksum_ok;
  assign bad        = accept && !in_checksum_ok;
  assign out_valid  = (occupancy != '0);
  assign pop        = out_valid && out_ready;
  assign out_flit   = mem[rd_ptr];
  assign fault      = (state == FAULT);
  assign consec_inc = consec + CW'(1);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_flit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      consec    <= '0;
      bo_cnt    <= '0;
      ack       <= 1'b0;
      nack      <= 1'b0;
      err_count <= '0;
    end else begin
      ack  <= push;
      nack <= bad;

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      occupancy <= occupancy + (PW + 1)'(1);
      else if (pop && !push) occupancy <= occupancy - (PW + 1)'(1);

      if (bad && (err_count != '1)) err_count <= err_count + ERR_CNT_WIDTH'(1);

      case (state)
        RUN: begin
          if (push) begin
            consec <= '0;
          end else if (bad) begin
            consec <= consec_inc;
            if (consec_inc == RETRY_LIM) begin
              state <= FAULT;
            end else begin
              state  <= BACKOFF;
              bo_cnt <= BO_LOAD;
            end
          end
        end
        BACKOFF: begin
          // Leaving on the count of 1 gives exactly BACKOFF_CYCLES stalled cycles.
          if (bo_cnt == BW'(1)) state <= RUN;
          else                  bo_cnt <= bo_cnt - BW'(1);
        end
        FAULT: begin
          if (clear_fault) begin
            state  <= RUN;
            consec <= '0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_flit_rx_buffer.sv
// Bench for flit_rx_buffer: directed scenarios plus random traffic, checked by
// a cycle-level reference model and an in-order scoreboard of delivered flits.
module tb_flit_rx_buffer;

  localparam int DEPTH   = 4;
  localparam int RETRY   = 3;
  localparam int BACKOFF = 4;
  localparam int ERR_MAX = 7;  // ERR_CNT_WIDTH = 3

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  types::flit_t in_flit = '0;
  logic         in_checksum_ok = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  types::flit_t out_flit;
  logic         ack;
  logic         nack;
  logic         fault;
  logic         clear_fault = 1'b0;
  logic [2:0]   occupancy;
  logic [2:0]   err_count;

  flit_rx_buffer #(
    .DEPTH(DEPTH),
    .MAX_RETRY(RETRY),
    .BACKOFF_CYCLES(BACKOFF),
    .ERR_CNT_WIDTH(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
    .in_checksum_ok(in_checksum_ok),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .ack(ack), .nack(nack), .fault(fault), .clear_fault(clear_fault),
    .occupancy(occupancy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: link-level rules expressed as counts and a queue.
  int           m_occ = 0;
  int           m_wait = 0;
  int           m_consec = 0;
  int           m_err = 0;
  bit           m_fault = 0;
  bit           m_ack = 0;
  bit           m_nack = 0;
  bit           m_acc = 0;
  bit           m_pop = 0;
  types::flit_t exp_q[$];

  function automatic bit m_ready();
    return !m_fault && (m_wait == 0) && (m_occ < DEPTH);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_occ = 0; m_wait = 0; m_consec = 0; m_err = 0;
      m_fault = 0; m_ack = 0; m_nack = 0; m_acc = 0;
      exp_q.delete();
    end else begin
      m_acc  = in_valid && m_ready();
      m_pop  = (m_occ != 0) && out_ready;
      m_ack  = m_acc && in_checksum_ok;
      m_nack = m_acc && !in_checksum_ok;
      if (m_fault) begin
        if (clear_fault) begin
          m_fault  = 0;
          m_consec = 0;
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end
      if (m_ack) begin
        exp_q.push_back(in_flit);
        m_consec = 0;
      end
      if (m_nack) begin
        if (m_err < ERR_MAX) m_err++;
        m_consec++;
        if (m_consec == RETRY) m_fault = 1;
        else                   m_wait  = BACKOFF;
      end
      m_occ = m_occ + (m_ack ? 1 : 0) - (m_pop ? 1 : 0);
    end
  end

  // Monitor: sampled mid-cycle, after inputs settle and before the next edge.
  types::flit_t exp_flit;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, m_ready());
      chk("out_valid", out_valid, m_occ != 0);
      chk("occupancy", occupancy, m_occ);
      chk("ack", ack, m_ack);
      chk("nack", nack, m_nack);
      chk("fault", fault, m_fault);
      chk("err_count", err_count, m_err);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_flit: got=%0h expected=none (scoreboard empty) at %0t", out_flit, $time);
        end else begin
          exp_flit = exp_q.pop_front();
          chk("out_flit", 32'(out_flit), 32'(exp_flit));
        end
      end
    end
  end

  function automatic types::flit_t mk(input logic [7:0] p);
    types::flit_t f;
    f.payload  = p;
    f.checksum = ~p;
    return f;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    in_valid    = 1'b0;
    clear_fault = 1'b0;
    step(n);
  endtask

  task automatic check_reset_values();
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ack", ack, 0);
    chk("rst_nack", nack, 0);
    chk("rst_fault", fault, 0);
    chk("rst_err_count", err_count, 0);
  endtask

  task automatic do_reset();
    in_valid    = 1'b0;
    clear_fault = 1'b0;
    rst_n       = 1'b0;
    #1;
    check_reset_values();
    step(2);
    rst_n = 1'b1;
  endtask

  // Offer one flit and hold it until the model accepts it (bounded).
  task automatic send(input logic [7:0] p, input bit ok);
    int n = 0;
    in_valid       = 1'b1;
    in_flit        = mk(p);
    in_checksum_ok = ok;
    forever begin
      @(posedge clk);
      #1;
      if (m_acc) break;
      if (++n >= 40) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: payload=%0h not accepted after %0d cycles", p, n);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  int idx;
  int n;

  initial begin
    // Basic in-order delivery.
    #2;
    do_reset();
    out_ready = 1'b1;
    send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
    idle(4);
    chk("basic_occ_drained", occupancy, 0);
    chk("basic_err_count", err_count, 0);

    // Fill to DEPTH with consumer stalled, then release.
    out_ready      = 1'b0;
    in_valid       = 1'b1;
    in_checksum_ok = 1'b1;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_flit = mk(8'h40 + 8'(idx));
      step(1);
      if (m_acc) idx++;
    end
    chk("full_in_ready", in_ready, 0);
    chk("full_occupancy", occupancy, DEPTH);
    out_ready = 1'b1;
    for (int c = 0; c < 10 && idx < 5; c++) begin
      in_flit = mk(8'h40 + 8'(idx));
      step(1);
      if (m_acc) idx++;
    end
    idle(8);

    // Single bad flit, backoff length, then recovery.
    send(8'hB0, 0);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    chk("backoff_len", n, BACKOFF);
    step(1);
    send(8'h55, 1);
    idle(4);

    // Consecutive errors lead to FAULT, then clear.
    do_reset();
    send(8'hE1, 0); send(8'hE2, 0); send(8'hE3, 0);
    in_valid       = 1'b1;
    in_checksum_ok = 1'b1;
    in_flit        = mk(8'h77);
    step(20);
    chk("fault_held", fault, 1);
    chk("fault_in_ready", in_ready, 0);
    in_valid    = 1'b0;
    clear_fault = 1'b1;
    step(1);
    clear_fault = 1'b0;
    chk("clear_fault", fault, 0);
    chk("clear_in_ready", in_ready, 1);
    chk("fault_err_count", err_count, 3);
    idle(3);

    // Concurrent push/pop at occupancy 2 across pointer wrap.
    out_ready = 1'b0;
    send(8'hC0, 1); send(8'hC1, 1);
    out_ready      = 1'b1;
    in_valid       = 1'b1;
    in_checksum_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_flit = mk(8'hD0 + 8'(i));
      @(negedge clk);
      chk("steady_occ", occupancy, 2);
      @(posedge clk);
      #1;
    end
    idle(6);

    // Random traffic, including saturation of the 3-bit drop counter.
    for (int c = 0; c < 400; c++) begin
      in_valid       = 1'($urandom_range(0, 1));
      in_checksum_ok = ($urandom_range(0, 2) != 0);
      in_flit        = types::flit_t'(16'($urandom));
      out_ready      = ($urandom_range(0, 3) != 0);
      clear_fault    = ($urandom_range(0, 7) == 0);
      step(1);
    end
    out_ready = 1'b1;
    idle(3);
    clear_fault = 1'b1;
    step(1);
    idle(10);

    // Reset in the middle of BACKOFF with three flits queued.
    do_reset();
    out_ready = 1'b0;
    send(8'hA1, 1); send(8'hA2, 1); send(8'hA3, 1);
    send(8'hAB, 0);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    chk("rst_in_ready", in_ready, 1);
    step(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
